// File: rtl/sprite_frame_cache.sv
// sprite_frame_cache
// Double-buffered on-chip copy of the current animation frame for NUM_SPR
// sprites. During vertical blanking each sprite's frame is copied out of the
// VRAM sprite sheet into that sprite's back bank through a req/ack pixel port.
// When blanking ends, a completed fill swaps back and front banks. An
// incomplete fill is abandoned, and the renderer keeps the old frame.
//
// Ports
//   Clk, Reset          system clock, synchronous active-high reset
//   DrawX, DrawY        current raster position (trigger / end-of-blank detect)
//   anim_x, anim_y      per-sprite frame origin in the sheet, sprite s at [10*s+:10]
//   vram_req/x/y        pixel fetch request and its sheet coordinate
//   vram_ack, vram_rgb  fetch accepted; pixel data valid in the same cycle
//   rd_sel/x/y, rd_rgb  renderer read port, registered, 1-cycle latency
//   fill_busy           high while in LOCK or FILL
//   fill_ovr            1-cycle pulse when blanking ends before the fill completes
//   state_dbg           current FSM state (IDLE=0, LOCK=1, FILL=2, DONE=3)
//
// Handshake: vram_req/vram_x/vram_y are a request that stays stable until a
// cycle in which vram_ack is high. That cycle consumes the pixel on vram_rgb,
// and the next address appears on the following cycle. Consecutive ack cycles
// therefore transfer one pixel per cycle.
module sprite_frame_cache #(
   parameter int              NUM_SPR  = 2,
   parameter int              SPR_W    = 106,
   parameter int              SPR_H    = 160,
   parameter int              PIX_W    = 8,
   parameter int              VB_START = 481,
   parameter logic [PIX_W-1:0] TRANSP  = {PIX_W{1'b0}},
   // rd_sel can encode one value past the last sprite, so an out-of-range select is expressible
   parameter int              SEL_W    = $clog2(NUM_SPR + 1)
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   input  logic [10*NUM_SPR-1:0] anim_x,
   input  logic [10*NUM_SPR-1:0] anim_y,
   output logic                  vram_req,
   output logic [9:0]            vram_x,
   output logic [9:0]            vram_y,
   input  logic                  vram_ack,
   input  logic [PIX_W-1:0]      vram_rgb,
   input  logic [SEL_W-1:0]      rd_sel,
   input  logic [9:0]            rd_x,
   input  logic [9:0]            rd_y,
   output logic [PIX_W-1:0]      rd_rgb,
   output logic                  fill_busy,
   output logic                  fill_ovr,
   output logic [1:0]            state_dbg
);

   localparam int DEPTH = SPR_W * SPR_H;
   localparam int AW    = $clog2(DEPTH);
   localparam int SW    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
   localparam int XW    = $clog2(SPR_W);
   localparam int YW    = $clog2(SPR_H);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOCK = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       s_q;
   logic [XW-1:0]       x_q;
   logic [YW-1:0]       y_q;
   logic [9:0]          ax_lock [NUM_SPR];
   logic [9:0]          ay_lock [NUM_SPR];
   logic [NUM_SPR-1:0]  front_q;

   // Memory index is {sprite, bank}. The bank currently shown is front_q[sprite].
   logic [PIX_W-1:0]    mem [2*NUM_SPR][DEPTH];

   logic                trigger, leave, last_pix;
   logic                do_lock, do_ack, do_swap;
   logic [AW-1:0]       wr_addr, rd_addr;
   logic                rd_ok;
   logic [SW-1:0]       rd_s;

   assign trigger   = (DrawY == 10'(VB_START)) && (DrawX == 10'd0);
   assign leave     = (DrawY == 10'd0) && (DrawX == 10'd0);
   assign last_pix  = (s_q == SW'(NUM_SPR - 1)) && (y_q == YW'(SPR_H - 1)) &&
                      (x_q == XW'(SPR_W - 1));
   assign state_dbg = state_q;

   // Next state and outputs. Leaving blanking has priority over a pending
   // ack, so an aborted fill never writes its final pixel.
   always_comb begin
      state_d   = state_q;
      vram_req  = 1'b0;
      vram_x    = 10'd0;
      vram_y    = 10'd0;
      fill_busy = 1'b0;
      fill_ovr  = 1'b0;
      do_lock   = 1'b0;
      do_ack    = 1'b0;
      do_swap   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trigger) state_d = S_LOCK;
         end
         S_LOCK: begin
            fill_busy = 1'b1;
            if (leave) begin
               fill_ovr = 1'b1;
               state_d  = S_IDLE;
            end else begin
               do_lock = 1'b1;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            fill_busy = 1'b1;
            if (leave) begin
               fill_ovr = 1'b1;
               state_d  = S_IDLE;
            end else begin
               vram_req = 1'b1;
               // 10-bit adds wrap modulo 1024 across the sheet edge
               vram_x   = ax_lock[s_q] + 10'(x_q);
               vram_y   = ay_lock[s_q] + 10'(y_q);
               if (vram_ack) begin
                  do_ack = 1'b1;
                  if (last_pix) state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (leave) begin
               do_swap = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         front_q <= '0;
         s_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         for (int i = 0; i < NUM_SPR; i++) begin
            ax_lock[i] <= 10'd0;
            ay_lock[i] <= 10'd0;
         end
      end else begin
         state_q <= state_d;
         if (do_lock) begin
            for (int i = 0; i < NUM_SPR; i++) begin
               ax_lock[i] <= anim_x[10*i +: 10];
               ay_lock[i] <= anim_y[10*i +: 10];
            end
            s_q <= '0;
            x_q <= '0;
            y_q <= '0;
         end
         if (do_ack) begin
            if (x_q == XW'(SPR_W - 1)) begin
               x_q <= '0;
               if (y_q == YW'(SPR_H - 1)) begin
                  y_q <= '0;
                  s_q <= s_q + 1'b1;
               end else begin
                  y_q <= y_q + 1'b1;
               end
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
         if (do_swap) front_q <= ~front_q;
      end
   end

   assign wr_addr = AW'(32'(y_q) * SPR_W + 32'(x_q));

   // Fill writes always target the back bank of the sprite being copied.
   always_ff @(posedge Clk) begin
      if (do_ack && !Reset)
         mem[{s_q, ~front_q[s_q]}][wr_addr] <= vram_rgb;
   end

   assign rd_ok   = (rd_sel < SEL_W'(NUM_SPR)) && (rd_x < 10'(SPR_W)) && (rd_y < 10'(SPR_H));
   assign rd_s    = SW'(rd_sel);
   assign rd_addr = AW'(32'(rd_y) * SPR_W + 32'(rd_x));

   // The read samples front_q before the swap edge updates it. A read issued
   // in the swap cycle therefore still returns the old frame.
   always_ff @(posedge Clk) begin
      if (Reset)
         rd_rgb <= {PIX_W{1'b0}};
      else if (!rd_ok)
         rd_rgb <= TRANSP;
      else
         rd_rgb <= mem[{rd_s, front_q[rd_s]}][rd_addr];
   end

endmodule

// File: tb/tb_sprite_frame_cache.sv
module tb_sprite_frame_cache;

  localparam int NUM_SPR = 2;
  localparam int PIX_W   = 8;
  localparam int SEL_W   = 2;
  localparam int N_PIX   = 2 * 106 * 160;

  // ---------------- clock / reset / signals ----------------
  logic               Clk = 1'b0;
  logic               Reset;
  logic [9:0]         DrawX, DrawY;
  logic [19:0]        anim_x, anim_y;
  logic               vram_req;
  logic [9:0]         vram_x, vram_y;
  logic               vram_ack;
  logic [PIX_W-1:0]   vram_rgb;
  logic [SEL_W-1:0]   rd_sel;
  logic [9:0]         rd_x, rd_y;
  logic [PIX_W-1:0]   rd_rgb;
  logic               fill_busy, fill_ovr;
  logic [1:0]         state_dbg;

  always #5 Clk = ~Clk;

  // VRAM sheet content: pixel at (x, y) is (x ^ y)[7:0]
  assign vram_rgb = vram_x[7:0] ^ vram_y[7:0];

  sprite_frame_cache dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .anim_x(anim_x), .anim_y(anim_y),
    .vram_req(vram_req), .vram_x(vram_x), .vram_y(vram_y),
    .vram_ack(vram_ack), .vram_rgb(vram_rgb),
    .rd_sel(rd_sel), .rd_x(rd_x), .rd_y(rd_y), .rd_rgb(rd_rgb),
    .fill_busy(fill_busy), .fill_ovr(fill_ovr), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int               n_tests = 0;
  int               n_fail  = 0;
  int               ovr_cnt = 0;
  logic [PIX_W-1:0] exp_q[$];
  string            name_q[$];
  logic             rd_issue = 1'b0;
  logic             rd_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge Clk) rd_v <= rd_issue;

  // counts fill_ovr pulses (sampled at the edge, inputs stable)
  always @(posedge Clk) if (!Reset && fill_ovr) ovr_cnt++;

  // read monitor: pops the expectation for each issued read one cycle later
  always @(negedge Clk) begin
    if (rd_v) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", {24'd0, rd_rgb}, 32'hFFFF_FFFF);
      end else begin
        chk(name_q.pop_front(), {24'd0, rd_rgb}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input string name, input int sel, input int x, input int y,
                         input logic [PIX_W-1:0] e);
    rd_sel   = SEL_W'(sel);
    rd_x     = 10'(x);
    rd_y     = 10'(y);
    rd_issue = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge Clk);
    rd_issue = 1'b0;
  endtask

  task automatic trigger_fill();
    DrawY = 10'd481; DrawX = 10'd0;
    @(negedge Clk);
    DrawY = 10'd500; DrawX = 10'd1;
  endtask

  task automatic end_blank();
    DrawY = 10'd0; DrawX = 10'd0;
    @(negedge Clk);
    DrawY = 10'd500; DrawX = 10'd1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; DrawX = 10'd1; DrawY = 10'd10;
    anim_x = '0; anim_y = '0; vram_ack = 1'b0;
    rd_sel = '0; rd_x = '0; rd_y = '0;
    repeat (3) @(negedge Clk);

    // reset state
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_req",   {31'd0, vram_req}, 32'd0);
    chk("rst_vx",    {22'd0, vram_x}, 32'd0);
    chk("rst_vy",    {22'd0, vram_y}, 32'd0);
    chk("rst_rgb",   {24'd0, rd_rgb}, 32'd0);
    chk("rst_busy",  {31'd0, fill_busy}, 32'd0);
    chk("rst_ovr",   {31'd0, fill_ovr}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // ---- frame 1: full fill, sprite0 origin (100,200), sprite1 origin (1000,50)
    anim_x = {10'd1000, 10'd100};
    anim_y = {10'd50,   10'd200};
    trigger_fill();
    chk("lock_state", {30'd0, state_dbg}, 32'd1);
    chk("lock_busy",  {31'd0, fill_busy}, 32'd1);
    chk("lock_req",   {31'd0, vram_req}, 32'd0);
    @(negedge Clk);
    chk("fill_state", {30'd0, state_dbg}, 32'd2);
    // origin changes after LOCK must not affect fetch addresses
    anim_x = {10'd1000, 10'd7};
    // request held without ack for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("hold_req", {31'd0, vram_req}, 32'd1);
      chk("hold_vx",  {22'd0, vram_x}, 32'd100);
      chk("hold_vy",  {22'd0, vram_y}, 32'd200);
      @(negedge Clk);
    end
    vram_ack = 1'b1;
    for (int k = 0; k < N_PIX; k++) begin
      if (k == 106)   begin chk("x_wrap_vx", {22'd0, vram_x}, 32'd100); chk("x_wrap_vy", {22'd0, vram_y}, 32'd201); end
      if (k == 16960) begin chk("spr1_vx",   {22'd0, vram_x}, 32'd1000); chk("spr1_vy", {22'd0, vram_y}, 32'd50); end
      if (k == 17010) begin chk("wrap_vx",   {22'd0, vram_x}, 32'd26); chk("wrap_vy", {22'd0, vram_y}, 32'd50); end
      if (k == 33919) begin chk("last_vx",   {22'd0, vram_x}, 32'd81); chk("last_vy", {22'd0, vram_y}, 32'd209); end
      // a trigger mid-fill is ignored
      if (k == 100) begin DrawY = 10'd481; DrawX = 10'd0; end
      else          begin DrawY = 10'd500; DrawX = 10'd1; end
      @(negedge Clk);
    end
    vram_ack = 1'b0;
    chk("done_state", {30'd0, state_dbg}, 32'd3);
    chk("done_req",   {31'd0, vram_req}, 32'd0);
    chk("done_busy",  {31'd0, fill_busy}, 32'd0);
    repeat (3) @(negedge Clk);
    DrawY = 10'd0; DrawX = 10'd0;
    #1 chk("swap_no_ovr", {31'd0, fill_ovr}, 32'd0);
    @(negedge Clk);
    DrawY = 10'd500; DrawX = 10'd1;
    chk("swap_idle", {30'd0, state_dbg}, 32'd0);

    // hand-computed (ax+x mod 1024) ^ (ay+y mod 1024), low 8 bits
    do_read("f1_s0_0_0",     0, 0,   0,   8'hAC);
    do_read("f1_s0_10_20",   0, 10,  20,  8'hB2);
    do_read("f1_s0_105_159", 0, 105, 159, 8'hAA);
    do_read("f1_s1_0_0",     1, 0,   0,   8'hDA);
    do_read("f1_s1_50_10",   1, 50,  10,  8'h26);
    do_read("f1_s1_105_159", 1, 105, 159, 8'h80);
    do_read("oor_x",         0, 106, 0,   8'h00);
    do_read("oor_y",         0, 0,   160, 8'h00);
    do_read("oor_sel",       2, 0,   0,   8'h00);
    repeat (2) @(negedge Clk);
    chk("ovr_after_f1", ovr_cnt, 32'd0);

    // ---- frame 2: ack every 3rd cycle, blanking too short -> overrun
    anim_x = '0; anim_y = '0;
    trigger_fill();
    for (int i = 0; i < 300; i++) begin
      vram_ack = (i % 3 == 2);
      @(negedge Clk);
    end
    vram_ack = 1'b0;
    chk("ovr_busy", {31'd0, fill_busy}, 32'd1);
    DrawY = 10'd0; DrawX = 10'd0;
    #1;
    chk("ovr_pulse", {31'd0, fill_ovr}, 32'd1);
    chk("ovr_req",   {31'd0, vram_req}, 32'd0);
    @(negedge Clk);
    DrawY = 10'd500; DrawX = 10'd1;
    chk("ovr_idle",  {30'd0, state_dbg}, 32'd0);
    chk("ovr_low",   {31'd0, fill_ovr}, 32'd0);
    chk("ovr_count", ovr_cnt, 32'd1);
    do_read("f2_keep_s0", 0, 0,   0,   8'hAC);
    do_read("f2_keep_s1", 1, 105, 159, 8'h80);

    // ---- reset during fill: sprite0 origin (3,4), 5 pixels written then reset
    anim_x = {10'd1000, 10'd3};
    anim_y = {10'd50,   10'd4};
    trigger_fill();
    vram_ack = 1'b1;
    repeat (6) @(negedge Clk);
    chk("rf_vx", {22'd0, vram_x}, 32'd8);
    chk("rf_vy", {22'd0, vram_y}, 32'd4);
    Reset = 1'b1; vram_ack = 1'b0;
    @(negedge Clk);
    chk("rf_req",   {31'd0, vram_req}, 32'd0);
    chk("rf_busy",  {31'd0, fill_busy}, 32'd0);
    chk("rf_state", {30'd0, state_dbg}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    end_blank();
    chk("rf_state2", {30'd0, state_dbg}, 32'd0);
    // front select is 0 after reset and stays 0: bank 0 holds the partial
    // fills (frame 2 origin (0,0), then 5 pixels at origin (3,4))
    do_read("rf_s0_0", 0, 0,  0, 8'h07);
    do_read("rf_s0_4", 0, 4,  0, 8'h03);
    do_read("rf_s0_5", 0, 5,  0, 8'h05);
    do_read("rf_s0_50", 0, 50, 0, 8'h32);
    repeat (3) @(negedge Clk);
    chk("rf_ovr_count", ovr_cnt, 32'd1);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
